// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Two-master arbiter in front of a single RAM-style slave port. The slave
//   returns read data one cycle after a read is issued.
//
//   Arbitration: when exactly one master requests, it is granted. When both
//   request, the master that was not granted most recently wins. Optional
//   burst locking is compiled in when MEM_ARB_LOCK_EN is defined. While a
//   master holds the lock, only that master is granted. After MAX_LOCK
//   consecutive locked grants, if the other master is waiting, the lock is
//   dropped so that the other master is granted next.
//
//   Handshake: a master raises mX_req_i and holds we/addr/wdata stable until
//   it sees mX_gnt_o=1 in the same cycle. That cycle is the access cycle on the
//   slave port. A granted read (we==0) returns mX_rvalid_o/mX_rdata_o exactly
//   one cycle later.
//
// Parameters
//   ADDR_W    address width on all ports
//   MAX_LOCK  cap on consecutive grants to a locked master (2..255)
//
// Ports
//   clk, reset                       clock, synchronous active-high reset
//   mX_req_i, mX_we_i, mX_addr_i     master X request, byte enables, address
//   mX_wdata_i, mX_lock_i            master X write data, burst lock request
//   mX_gnt_o                         master X accepted this cycle
//   mX_rvalid_o, mX_rdata_o          master X read response
//   s_en_o, s_we_o, s_addr_o,        slave access (RAM port B style)
//   s_wdata_o, s_rdata_i
//   dbg_state_o                      FSM state: 0 IDLE, 1 OWN0, 2 OWN1
//
// Configuration macro: MEM_ARB_LOCK_EN (undefined: pure round-robin, lock
// inputs ignored, FSM stays in IDLE)

module mem_port_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int MAX_LOCK = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_req_i,
   input  logic [3:0]        m0_we_i,
   input  logic [ADDR_W-1:0] m0_addr_i,
   input  logic [31:0]       m0_wdata_i,
   input  logic              m0_lock_i,
   output logic              m0_gnt_o,
   output logic              m0_rvalid_o,
   output logic [31:0]       m0_rdata_o,
   input  logic              m1_req_i,
   input  logic [3:0]        m1_we_i,
   input  logic [ADDR_W-1:0] m1_addr_i,
   input  logic [31:0]       m1_wdata_i,
   input  logic              m1_lock_i,
   output logic              m1_gnt_o,
   output logic              m1_rvalid_o,
   output logic [31:0]       m1_rdata_o,
   output logic              s_en_o,
   output logic [3:0]        s_we_o,
   output logic [ADDR_W-1:0] s_addr_o,
   output logic [31:0]       s_wdata_o,
   input  logic [31:0]       s_rdata_i,
   output logic [1:0]        dbg_state_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   localparam logic [7:0] MAX_CNT = 8'(MAX_LOCK);

   state_t     state_q, state_d;
   logic       last_q, last_d;          // 1: m1 was granted most recently
   logic [7:0] lock_cnt_q, lock_cnt_d;  // grants issued under the current lock
   logic       rvalid0_q, rvalid0_d;
   logic       rvalid1_q, rvalid1_d;
   logic       gnt0, gnt1;
   logic       cap_hit;

   // The counter saturates at MAX_CNT. Once it is there, a waiting
   // competitor forces the lock to be released.
   assign cap_hit = (lock_cnt_q >= MAX_CNT);

`ifndef MEM_ARB_LOCK_EN
   logic unused_lock;
   assign unused_lock = m0_lock_i ^ m1_lock_i;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         last_q     <= 1'b1;
         lock_cnt_q <= 8'd0;
         rvalid0_q  <= 1'b0;
         rvalid1_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         lock_cnt_q <= lock_cnt_d;
         rvalid0_q  <= rvalid0_d;
         rvalid1_q  <= rvalid1_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      lock_cnt_d = lock_cnt_q;
      last_d     = last_q;
      if (gnt0) begin
         last_d = 1'b0;
      end else if (gnt1) begin
         last_d = 1'b1;
      end
      rvalid0_d = gnt0 && (m0_we_i == 4'b0000);
      rvalid1_d = gnt1 && (m1_we_i == 4'b0000);
`ifdef MEM_ARB_LOCK_EN
      case (state_q)
         IDLE: begin
            if (gnt0 && m0_lock_i) begin
               state_d    = OWN0;
               lock_cnt_d = 8'd1;
            end else if (gnt1 && m1_lock_i) begin
               state_d    = OWN1;
               lock_cnt_d = 8'd1;
            end
         end
         OWN0: begin
            if (!m0_req_i || (cap_hit && m1_req_i) || (gnt0 && !m0_lock_i)) begin
               state_d    = IDLE;
               lock_cnt_d = 8'd0;
            end else if (gnt0) begin
               if (!cap_hit) begin
                  lock_cnt_d = lock_cnt_q + 8'd1;
               end
               // This grant reaches the cap. Release now so that the waiting
               // master wins the round-robin in the next cycle.
               if ((lock_cnt_q + 8'd1 == MAX_CNT) && m1_req_i) begin
                  state_d    = IDLE;
                  lock_cnt_d = 8'd0;
               end
            end
         end
         OWN1: begin
            if (!m1_req_i || (cap_hit && m0_req_i) || (gnt1 && !m1_lock_i)) begin
               state_d    = IDLE;
               lock_cnt_d = 8'd0;
            end else if (gnt1) begin
               if (!cap_hit) begin
                  lock_cnt_d = lock_cnt_q + 8'd1;
               end
               if ((lock_cnt_q + 8'd1 == MAX_CNT) && m0_req_i) begin
                  state_d    = IDLE;
                  lock_cnt_d = 8'd0;
               end
            end
         end
         default: begin
            state_d    = IDLE;
            lock_cnt_d = 8'd0;
         end
      endcase
`else
      state_d    = IDLE;
      lock_cnt_d = 8'd0;
`endif
   end

   // Output logic: grants, slave mux, read responses
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!reset) begin
         case (state_q)
            IDLE: begin
               if (m0_req_i && m1_req_i) begin
                  gnt0 = last_q;
                  gnt1 = !last_q;
               end else begin
                  gnt0 = m0_req_i;
                  gnt1 = m1_req_i;
               end
            end
            OWN0:    gnt0 = m0_req_i && !(cap_hit && m1_req_i);
            OWN1:    gnt1 = m1_req_i && !(cap_hit && m0_req_i);
            default: ;
         endcase
      end
      m0_gnt_o = gnt0;
      m1_gnt_o = gnt1;

      s_en_o    = gnt0 | gnt1;
      s_we_o    = 4'b0000;
      s_addr_o  = '0;
      s_wdata_o = 32'd0;
      if (gnt0) begin
         s_we_o    = m0_we_i;
         s_addr_o  = m0_addr_i;
         s_wdata_o = m0_wdata_i;
      end else if (gnt1) begin
         s_we_o    = m1_we_i;
         s_addr_o  = m1_addr_i;
         s_wdata_o = m1_wdata_i;
      end

      // A response that is due in a reset cycle is dropped.
      m0_rvalid_o = rvalid0_q && !reset;
      m1_rvalid_o = rvalid1_q && !reset;
      m0_rdata_o  = m0_rvalid_o ? s_rdata_i : 32'd0;
      m1_rdata_o  = m1_rvalid_o ? s_rdata_i : 32'd0;
      dbg_state_o = state_q;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: address width on all ports.
REQ-002 SHALL have parameter MAX_LOCK, default 8: maximum consecutive grants to one locked master; range 2..255.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have ports m0_req_i/m1_req_i, input, 1 each: master access request.
REQ-006 SHALL have ports m0_we_i/m1_we_i, input, 4 each: byte write enables; zero means read.
REQ-007 SHALL have ports m0_addr_i/m1_addr_i, input, ADDR_W each: access address.
REQ-008 SHALL have ports m0_wdata_i/m1_wdata_i, input, 32 each: write data.
REQ-009 SHALL have ports m0_lock_i/m1_lock_i, input, 1 each: burst lock request (see REQ-030).
REQ-010 SHALL have ports m0_gnt_o/m1_gnt_o, output, 1 each: access accepted this cycle.
REQ-011 SHALL have ports m0_rvalid_o/m1_rvalid_o, output, 1 each: read data valid.
REQ-012 SHALL have ports m0_rdata_o/m1_rdata_o, output, 32 each: read data.
REQ-013 SHALL have ports s_en_o, s_we_o[3:0], s_addr_o[ADDR_W-1:0], s_wdata_o[31:0], output: slave port, RAM port B protocol.
REQ-014 SHALL have port s_rdata_i, input, 32: slave read data, valid one cycle after a read.

Function
REQ-015 SHALL grant at most one master per cycle; grants are combinational from the current req inputs and registered state.
REQ-016 SHALL grant the only requester when exactly one req is high.
REQ-017 SHALL, when both request with no lock active, grant the master not granted most recently (round-robin).
REQ-018 SHALL drive s_en_o=1 and forward the granted master's we/addr/wdata unchanged in the grant cycle; with no grant, s_en_o=0 and s_we_o/s_addr_o/s_wdata_o=0.
REQ-019 SHALL pulse mX_rvalid_o exactly one cycle after a granted read (we==0) by master X; never for writes.
REQ-020 SHALL drive mX_rdata_o=s_rdata_i while mX_rvalid_o=1, and 0 otherwise.
REQ-021 SHALL support back-to-back grants; a read response and a new grant may occur in the same cycle, to the same or different masters.
REQ-022 SHALL keep a non-granted master's request pending without side effects; masters hold req/we/addr/wdata stable until gnt.
REQ-023 SHALL update the last-granted register only on cycles where a grant is issued.
REQ-024 SHALL use a state machine with states IDLE, OWN0, OWN1: IDLE when no lock is held; OWNx while master x holds the lock.

Reset
REQ-025 SHALL, on reset=1 at a clock edge, enter IDLE, set last-granted to m1 (so m0 wins the first contention), clear the lock counter and both rvalid outputs.
REQ-026 SHALL force all gnt outputs and s_en_o to 0 during any cycle reset=1 is sampled high.
REQ-027 SHALL drop a pending read response if reset is asserted in the cycle it would be returned; no rvalid follows reset.

Configuration
REQ-028 SHALL compile the lock feature only when macro MEM_ARB_LOCK_EN is defined.
REQ-029 SHALL, without MEM_ARB_LOCK_EN, ignore m0_lock_i/m1_lock_i and remain in IDLE permanently (pure round-robin).
REQ-030 SHALL, with MEM_ARB_LOCK_EN, move IDLE->OWNx when master x is granted with lock_i=1; in OWNx grant only master x; lock counter counts grants from 1.
REQ-031 SHALL leave OWNx->IDLE when master x is granted with lock_i=0, when master x drops req, or when the counter reaches MAX_LOCK and the other master is requesting (fairness cap); on cap exit the other master is granted next cycle.
REQ-032 SHALL clear the lock counter on every exit to IDLE.

Verification
REQ-033 SHALL test: after reset, m0 and m1 both read in cycle 1 -> m0_gnt=1, m1 granted cycle 2; m0_rvalid cycle 2, m1_rvalid cycle 3.
REQ-034 SHALL test: both masters request continuously for 6 cycles -> grants alternate m0,m1,m0,m1,m0,m1.
REQ-035 SHALL test: m1 writes we=4'hF addr 0x100 data 0xDEADBEEF, then m0 reads 0x100 -> m0_rdata=0xDEADBEEF with rvalid, no rvalid for the write.
REQ-036 SHALL test (MEM_ARB_LOCK_EN, MAX_LOCK=8): m0 locked and m1 requesting -> m0 granted exactly 8 consecutive cycles, then m1 granted.
REQ-037 SHALL test: reset asserted in cycle after granted read -> no rvalid, all outputs 0, next contention granted to m0.
REQ-038 SHALL test: no requests for 4 cycles -> s_en_o=0, no gnt, last-granted unchanged.
